// File: rtl/down_count_pkg.sv
// Shared types and default sizing for the down-count timer.
package down_count_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH    = 4;
   localparam int DEFAULT_PRESCALE = 1;

endpackage

// File: rtl/down_count_timer_tick_prescaler.sv
// Decrement tick generator: one tick per PRESCALE enabled cycles, tick == en at PRESCALE=1.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(PRESCALE - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tick = en && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control, enable pause and abort.
// Define DOWN_COUNT_AUTO_RELOAD_EN to make DONE reload the last start value and keep running.
module down_count_timer
   import down_count_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int PRESCALE = DEFAULT_PRESCALE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick;
   logic             pre_clear;

`ifdef DOWN_COUNT_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload_q, reload_d;
`endif

   // Prescaler only accumulates while running, so every load/reload starts a fresh period.
   assign pre_clear = (state_q != RUN);

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clear (pre_clear),
      .en    (en),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
      reload_d = reload_q;
`endif
      case (state_q)
         IDLE: begin
            if (abort) begin
               count_d = '0;
            end else if (start) begin
               count_d = load_val;
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
               reload_d = load_val;
`endif
               state_d = (load_val == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else if (tick && (count_q != '0)) begin
               count_d = count_q - WIDTH'(1);
               if (count_q == WIDTH'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (abort) begin
               state_d = IDLE;
               count_d = '0;
            end else begin
`ifdef DOWN_COUNT_AUTO_RELOAD_EN
               count_d = reload_q;
               state_d = (reload_q == '0) ? DONE : RUN;
`else
               count_d = '0;
               state_d = IDLE;
`endif
            end
         end
         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

`ifdef DOWN_COUNT_AUTO_RELOAD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_q <= '0;
      end else begin
         reload_q <= reload_d;
      end
   end
`endif

   assign count = count_q;
   assign busy  = (state_q != IDLE);
   assign done  = (state_q == DONE);

endmodule

// File: doc/down_count_timer.md
DOWN_COUNT_TIMER -- requirements
Module: down_count_timer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the counter and load-value width in bits.
REQ-002 Parameter PRESCALE, default 1, SHALL set the number of enabled clk cycles per decrement (legal range 1..255).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be the request to load load_val and begin counting; sampled only in IDLE.
REQ-006 load_val  input  WIDTH  SHALL be the start value, captured on an accepted start.
REQ-007 en  input  1  SHALL be the count enable; en=0 pauses the count and the prescaler in RUN.
REQ-008 abort  input  1  SHALL be the cancel request; acts in any state.
REQ-009 count  output  WIDTH  SHALL be the current registered count value.
REQ-010 busy  output  1  SHALL be high in RUN and DONE states.
REQ-011 done  output  1  SHALL be a one-cycle pulse, high exactly while in DONE.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, state-encoded from the shared package.
REQ-013 IDLE: start=1, abort=0, load_val=L>0 at edge k SHALL give count=L and RUN after edge k; the prescaler clears.
REQ-014 IDLE: start=1 with load_val=0 SHALL go straight to DONE with count=0 (done one cycle later, no RUN).
REQ-015 RUN: count SHALL decrement by 1 on every PRESCALE-th cycle with en=1; cycles with en=0 are not counted.
REQ-016 RUN: the decrement that makes count 0 SHALL also move the FSM to DONE at the same edge.
REQ-017 With PRESCALE=1 and en held high, done SHALL be high L cycles after the edge that loaded L.
REQ-018 count SHALL never wrap below 0; DONE is the only exit at count 0.
REQ-019 start in RUN or DONE SHALL be ignored; load_val SHALL only be captured in IDLE.
REQ-020 abort=1 in RUN or DONE SHALL force IDLE and count=0 at the next edge, with no done pulse.
REQ-021 abort and start both high in IDLE SHALL give abort priority; the FSM stays in IDLE with count=0.
REQ-022 DONE SHALL last exactly one cycle, then exit per REQ-026/REQ-027.
REQ-023 In IDLE, count SHALL hold its last value.

Reset
REQ-024 reset high SHALL immediately force: state IDLE, count=0, busy=0, done=0, prescaler=0, stored reload value=0.
REQ-025 reset asserted mid-RUN or in DONE SHALL abandon the operation; no done pulse occurs after release.

Configuration
REQ-026 With DOWN_COUNT_AUTO_RELOAD_EN defined: DONE SHALL reload count with the last captured load_val, clear the prescaler, and return to RUN. Period is L+1 cycles at PRESCALE=1. Only abort or reset returns to IDLE. A captured 0 keeps DONE repeating every cycle.
REQ-027 Without DOWN_COUNT_AUTO_RELOAD_EN: DONE SHALL return to IDLE with count=0, and no reload register is built.

Structure
REQ-028 Package down_count_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH/PRESCALE constants.
REQ-029 Sub-module tick_prescaler SHALL generate the decrement tick: inputs clk, reset, clear, en; output tick; parameter PRESCALE. At PRESCALE=1, tick equals en.

Verification
REQ-030 reset; start with load_val=5, PRESCALE=1, en=1 -> count 5,4,3,2,1,0 on consecutive cycles; done high one cycle when count=0; busy=0 afterwards.
REQ-031 load_val=3, en toggled 1,0,1,0,1 -> count decrements only on en=1 cycles; done after the third enabled cycle.
REQ-032 load_val=6, abort at count=4 -> next cycle IDLE, count=0, no done pulse; a new start with load_val=2 works normally.
REQ-033 start with load_val=0 -> done pulse one cycle later, busy high for that one DONE cycle; start and abort together in IDLE -> nothing happens.
REQ-034 PRESCALE=3, load_val=2 -> count drops every 3 cycles and done is high 6 cycles after the load. With DOWN_COUNT_AUTO_RELOAD_EN, load_val=4 gives a done pulse every 5 cycles until abort.
REQ-035 reset pulsed while count=7 in RUN -> count=0 and state IDLE at once, no done pulse after release; start during RUN is ignored.
